// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared defaults, overlap constants and helpers for seq_det_prog
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 16;

    localparam logic OVL_OFF = 1'b0;
    localparam logic OVL_ON  = 1'b1;

    // Width needed to hold a length value in 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Low-ones mask covering the last len received bits; caller truncates
    // to its own history width.
    function automatic logic [31:0] len_mask(input int unsigned len);
        if (len >= 32)
            return '1;
        else
            return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
// Ports: clk, reset (async, active-high), inc (count one event),
//        clr (synchronous clear, wins over inc), count (CNT_W, holds at all-ones).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/seq_det_prog.sv
// rtl/seq_det_prog.sv - programmable serial bit-pattern detector with registered match pulse
// Optional feature macro: SEQ_DET_MATCH_COUNT_EN (match counter and cnt_clr present;
// otherwise match_count is tied to 0 and cnt_clr is ignored).
// Ports: clk, reset (async, active-high), sin/in_valid (gated serial bit),
//        cfg_load/cfg_pattern/cfg_len/cfg_overlap (runtime config, load clears history),
//        cnt_clr (clears match_count), match (one-cycle pulse), match_count (saturating).
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sin,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;

    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_in;
    logic               hit;

    always_comb begin
        hist_n = {hist_q[MAX_LEN-2:0], sin};
        fill_n = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
        mask   = MAX_LEN'(len_mask(32'(len_q)));
        len_in = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
        // A coincident cfg_load discards the bit, so it can never complete a pattern.
        hit    = in_valid && !cfg_load && (len_q != '0) && (fill_n >= len_q)
                 && (((hist_n ^ pat_q) & mask) == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= OVL_OFF;
            hist_q <= '0;
            fill_q <= '0;
            match  <= 1'b0;
        end else begin
            match <= hit;
            if (cfg_load) begin
                pat_q  <= cfg_pattern;
                len_q  <= len_in;
                ovl_q  <= cfg_overlap;
                hist_q <= '0;
                fill_q <= '0;
            end else if (in_valid) begin
                if (hit && (ovl_q == OVL_OFF)) begin
                    // Non-overlapping: matched bits are consumed.
                    hist_q <= '0;
                    fill_q <= '0;
                end else begin
                    hist_q <= hist_n;
                    fill_q <= fill_n;
                end
            end
        end
    end

`ifdef SEQ_DET_MATCH_COUNT_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (cnt_clr),
        .count (match_count)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// tb/tb_seq_det_prog.sv - scoreboard bench for seq_det_prog with directed vectors
module tb_seq_det_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       sin;
    logic       in_valid;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       cnt_clr;
    logic       match;
    logic [1:0] match_count;

    int n_vec  = 0;
    int n_miss = 0;

    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    seq_det_prog #(
        .MAX_LEN (8),
        .CNT_W   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sin         (sin),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_count (match_count)
    );

    function automatic logic [1:0] cnt_exp(input logic [1:0] c);
`ifdef SEQ_DET_MATCH_COUNT_EN
        return c;
`else
        return 2'd0;
`endif
    endfunction

    // One stimulus cycle; the expected outputs after the next edge go to the scoreboard.
    task automatic drive(input logic v, input logic s, input logic ld, input logic clr,
                         input logic em, input logic [1:0] ec);
        @(negedge clk);
        in_valid = v;
        sin      = s;
        cfg_load = ld;
        cnt_clr  = clr;
        exp_q.push_back({em, cnt_exp(ec)});
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic [1:0] ec);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ec);
    endtask

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: match/count got %b/%0d expected %b/%0d",
                     name, act[2], act[1:0], exp[2], exp[1:0]);
        end
    endtask

    // Monitor: outputs are compared one cycle after each issued vector.
    initial begin
        logic [2:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("vec%0d", n_vec), {match, match_count}, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; sin = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("reset_state", {match, match_count}, 3'b000);
        @(negedge clk);
        reset = 1'b0;

        // "1110" non-overlapping, two back-to-back patterns
        load(8'b1110, 4'd4, 1'b0, 2'd0);
        drive(1,1,0,0,0,0); drive(1,1,0,0,0,0); drive(1,1,0,0,0,0); drive(1,0,0,0,1,1);
        drive(1,1,0,0,0,1); drive(1,1,0,0,0,1); drive(1,1,0,0,0,1); drive(1,0,0,0,1,2);
        drive(0,0,0,1,0,0);

        // "101" overlapping then non-overlapping
        load(8'b101, 4'd3, 1'b1, 2'd0);
        drive(1,1,0,0,0,0); drive(1,0,0,0,0,0); drive(1,1,0,0,1,1); drive(1,0,0,0,0,1);
        drive(1,1,0,0,1,2);
        load(8'b101, 4'd3, 1'b0, 2'd2);
        drive(1,1,0,0,0,2); drive(1,0,0,0,0,2); drive(1,1,0,0,1,3); drive(1,0,0,0,0,3);
        drive(1,1,0,0,0,3);
        drive(0,0,0,1,0,0);

        // "11" overlapping across in_valid gaps
        load(8'b11, 4'd2, 1'b1, 2'd0);
        drive(1,1,0,0,0,0); drive(0,1,0,0,0,0); drive(1,1,0,0,1,1); drive(0,1,0,0,0,1);
        drive(1,1,0,0,1,2);

        // cfg_load colliding with the completing bit
        load(8'b1110, 4'd4, 1'b0, 2'd2);
        drive(1,1,0,0,0,2); drive(1,1,0,0,0,2); drive(1,1,0,0,0,2);
        drive(1,0,1,0,0,2);
        drive(1,0,0,0,0,2);
        drive(1,1,0,0,0,2); drive(1,1,0,0,0,2); drive(1,1,0,0,0,2); drive(1,0,0,0,1,3);

        // saturation after five hits, then cnt_clr coinciding with a hit
        drive(0,0,0,1,0,0);
        load(8'b11, 4'd2, 1'b1, 2'd0);
        drive(1,1,0,0,0,0); drive(1,1,0,0,1,1); drive(1,1,0,0,1,2); drive(1,1,0,0,1,3);
        drive(1,1,0,0,1,3); drive(1,1,0,0,1,3);
        drive(1,1,0,1,1,0);
        drive(1,1,0,0,1,1);

        // len=1 completes on the first accepted bit
        load(8'b1, 4'd1, 1'b0, 2'd1);
        drive(1,1,0,0,1,2); drive(1,0,0,0,0,2); drive(1,1,0,0,1,3);

        // len=0 disables detection
        load(8'b0, 4'd0, 1'b0, 2'd3);
        drive(1,0,0,0,0,3); drive(1,0,0,0,0,3); drive(1,0,0,0,0,3);

        // oversized length clamps to 8: 0xA5 sent MSB first
        load(8'hA5, 4'd15, 1'b0, 2'd3);
        drive(1,1,0,0,0,3); drive(1,0,0,0,0,3); drive(1,1,0,0,0,3); drive(1,0,0,0,0,3);
        drive(1,0,0,0,0,3); drive(1,1,0,0,0,3); drive(1,0,0,0,0,3); drive(1,1,0,0,1,3);

        // asynchronous reset mid-pattern
        load(8'b1110, 4'd4, 1'b0, 2'd3);
        drive(1,1,0,0,0,3); drive(1,1,0,0,0,3);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1 chk("async_reset", {match, match_count}, 3'b000);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1,1,0,0,0,0); drive(1,1,0,0,0,0); drive(1,1,0,0,0,0); drive(1,0,0,0,0,0);
        load(8'b1110, 4'd4, 1'b0, 2'd0);
        drive(1,1,0,0,0,0); drive(1,1,0,0,0,0); drive(1,1,0,0,0,0); drive(1,0,0,0,1,1);
        drive(0,0,0,0,0,1);

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Programmable serial bit-pattern detector, the parametrised successor to the fixed four-state "1110" non-overlapping detector. Pattern length (1..MAX_LEN), pattern value and overlap mode are runtime-loadable, with gated input, a registered match pulse and a saturating match counter. It sits on the serial receive path after bit recovery and feeds match events to framing and interrupt logic.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; legal range 2..32.
- CNT_W, 16: match counter width.
- LEN_W, $clog2(MAX_LEN+1): pattern length field width (derived; do not override).

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- sin  in  1  serial data bit
- in_valid  in  1  sin is sampled only when high
- cfg_load  in  1  latch cfg_pattern, cfg_len and cfg_overlap; clear history
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
- cfg_len  in  LEN_W  pattern length; 0 disables detection
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cnt_clr  in  1  synchronous clear of match_count
- match  out  1  registered one-cycle pulse per detected pattern
- match_count  out  CNT_W  saturating count of matches

## Operation
- Config registers: pat, len, ovl. Reset values: 0, 0, 0, so detection is disabled after reset.
- On cfg_load: latch all three config inputs. A cfg_len above MAX_LEN is clamped to MAX_LEN. Clear hist and fill.
- hist[MAX_LEN-1:0]: shift register of received bits. fill: count of bits received since the last clear, saturating at MAX_LEN.
- Accepted bit (in_valid=1, cfg_load=0):
  - hist_n = {hist[MAX_LEN-2:0], sin}
  - fill_n = min(fill+1, MAX_LEN)
- Hit when all of these hold:
  - len != 0
  - fill_n >= len
  - (hist_n & mask) == (pat & mask), where mask has the low len bits set
- On hit:
  - match <= 1.
  - If ovl=0: hist and fill clear to 0, so no bit of a matched pattern is reused.
  - If ovl=1: hist takes hist_n and fill takes fill_n, so a suffix can start the next match.
- On hit, match_count increments unless it is all-ones (saturates, never wraps).
- Precedence:
  - cfg_load beats in_valid: the bit is discarded and no hit is possible that cycle.
  - cnt_clr beats increment: the count becomes 0 and the coincident hit is lost from the count. match still pulses.
- in_valid=0: hist, fill and config hold. match <= 0.
- Reset mid-operation clears all state immediately; outputs go to 0 asynchronously.

## Timing
- Reset values: match=0, match_count=0.
- Latency: match rises on the clock edge that samples the completing bit, i.e. it is visible in the cycle after sin/in_valid are presented. Pulse width is exactly one cycle.
- match_count updates on the same edge as match.
- A pattern may complete on the first accepted bit after cfg_load only if len=1.
- Back-to-back hits are supported in both modes:
  - ovl=1, pattern "11", stream of 1s: a hit every accepted bit after the second.
  - ovl=0: a hit at most once per len accepted bits.
- Gaps in in_valid are transparent: the sequence continues across gaps.

## Configuration
- SEQ_DET_MATCH_COUNT_EN defined: match counter and cnt_clr logic present, as described above.
- Undefined: the counter is not synthesised, match_count is tied to 0 and cnt_clr is ignored. match behaviour is identical in both builds.

## Structure
- Package seq_det_pkg holds:
  - default MAX_LEN and CNT_W
  - LEN_W helper function
  - mask-generation function (len → low-ones mask)
  - overlap mode constants OVL_OFF=1'b0 and OVL_ON=1'b1
- One sub-module: sat_counter (CNT_W, inc, clr, count). It is instantiated only under SEQ_DET_MATCH_COUNT_EN.
- Compare and shift logic stay in seq_det_prog.

## Test plan
- Load pattern 4'b1110, len=4, ovl=0; stream 1,1,1,0,1,1,1,0 → match pulses after bits 4 and 8; match_count=2.
- Load pattern 3'b101, len=3, ovl=1; stream 1,0,1,0,1 → matches after bits 3 and 5. Same stream with ovl=0 → match after bit 3 only.
- Pattern 2'b11, len=2, ovl=1; in_valid toggling 1,0,1,0,1 with sin=1 → matches after the 2nd and 3rd accepted bits; no match in idle cycles.
- Assert cfg_load in the same cycle as the completing bit → no match; history cleared; the next full pattern matches normally.
- With CNT_W=2, drive 5 matches → match_count=3 (saturated). Assert cnt_clr together with a hit → match=1, match_count=0.
- Assert reset mid-pattern (after 2 of 4 bits) → match=0, match_count=0, len=0. No match until reload, even if the pattern then appears.
